reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised reset_n release, stretch, then staggered release of NUM_OUT resets.
// Define RESET_SEQ_COUNT_EN to build the saturating completed-sequence counter on rst_count.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned NUM_OUT        = 3,
  parameter int unsigned STAGE_GAP      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] reset,
  output logic               rst_done,
  output logic [7:0]         rst_count
);

  typedef enum logic [1:0] {
    StSync,
    StStretch,
    StRelease,
    StRun
  } state_e;

  localparam logic [7:0] StretchLoad = 8'(STRETCH_CYCLES);
  // Leaving SYNC already spends one cycle of the stretch window.
  localparam logic [7:0] StretchFirst = 8'(STRETCH_CYCLES - 1);
  localparam logic [7:0] GapLoad      = 8'(STAGE_GAP);
  localparam bit         StretchOne   = (STRETCH_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_done;
  state_e                 state_q;
  logic [NUM_OUT-1:0]     reset_q;
  logic [NUM_OUT-1:0]     reset_shift;
  logic                   rst_done_q;
  logic [7:0]             stretch_q;
  logic [7:0]             gap_q;
  logic                   last_release;
  logic                   stretch_expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done = sync_q[SYNC_STAGES-1];

  // Outputs release LSB first, so each release is a zero-filling left shift.
  assign reset_shift  = reset_q << 1;
  assign last_release = (reset_shift == '0);

  assign stretch_expire = ((state_q == StSync) && sync_done && StretchOne) ||
                          ((state_q == StStretch) && (stretch_q == 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StSync;
      reset_q    <= '1;
      rst_done_q <= 1'b0;
      stretch_q  <= '0;
      gap_q      <= '0;
    end else if (sw_rst_req && (state_q != StSync)) begin
      state_q    <= StStretch;
      reset_q    <= '1;
      rst_done_q <= 1'b0;
      stretch_q  <= StretchLoad;
      gap_q      <= '0;
    end else begin
      unique case (state_q)
        StSync, StStretch: begin
          if (stretch_expire) begin
            reset_q   <= reset_shift;
            stretch_q <= '0;
            if (last_release) begin
              state_q    <= StRun;
              rst_done_q <= 1'b1;
            end else begin
              state_q <= StRelease;
              gap_q   <= GapLoad;
            end
          end else if (state_q == StSync) begin
            if (sync_done) begin
              state_q   <= StStretch;
              stretch_q <= StretchFirst;
            end
          end else begin
            stretch_q <= stretch_q - 8'd1;
          end
        end
        StRelease: begin
          if (gap_q == 8'd1) begin
            reset_q <= reset_shift;
            if (last_release) begin
              state_q    <= StRun;
              rst_done_q <= 1'b1;
              gap_q      <= '0;
            end else begin
              gap_q <= GapLoad;
            end
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StSync;
        end
      endcase
    end
  end

  assign reset    = reset_q;
  assign rst_done = rst_done_q;

`ifdef RESET_SEQ_COUNT_EN
  logic       done_prev_q;
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_prev_q <= 1'b0;
      count_q     <= '0;
    end else begin
      done_prev_q <= rst_done_q;
      if (rst_done_q && !done_prev_q && (count_q != 8'hff)) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign rst_count = count_q;
`else
  assign rst_count = 8'h00;
`endif

endmodule
